// File: rtl/vend_payment_fsm.sv
// Payment controller: latches the item price, accumulates coins, dispenses, returns change or refunds.
// Optional idle auto-refund in COLLECT is enabled by defining VEND_TIMEOUT_EN.
module vend_payment_fsm #(
   parameter int unsigned CREDIT_W       = 5,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [3:0]          price_binary,
   input  logic                coin_valid,
   input  logic [1:0]          coin_code,
   input  logic                cancel,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit,
   output logic                dispense,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change,
   output logic                coin_reject,
   output logic                timeout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DISPENSE,
      S_REFUND
   } state_t;

   state_t              state, state_nx;
   logic [3:0]          price_r, price_nx;
   logic [CREDIT_W-1:0] credit_nx;
   logic [CREDIT_W-1:0] chg_r, chg_nx;
   logic [CREDIT_W-1:0] coin_val, sum;
   logic                busy_nx, dispense_nx, change_valid_nx, coin_reject_nx, timeout_nx;
   logic [CREDIT_W-1:0] change_nx;
   logic                pay_out;

`ifdef VEND_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             to_r, to_nx;
   logic             timeout_hit;
`endif

   always_comb begin
      case (coin_code)
         2'b00:   coin_val = CREDIT_W'(1);
         2'b01:   coin_val = CREDIT_W'(2);
         2'b10:   coin_val = CREDIT_W'(5);
         default: coin_val = CREDIT_W'(10);
      endcase
   end

   assign sum = credit + (coin_valid ? coin_val : '0);

   always_comb begin
      state_nx  = state;
      price_nx  = price_r;
      credit_nx = credit;
      chg_nx    = chg_r;
`ifdef VEND_TIMEOUT_EN
      cnt_nx      = cnt;
      to_nx       = to_r;
      // An accepted coin or cancel in the same cycle always wins over the timeout.
      timeout_hit = !coin_valid && !cancel && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               price_nx  = price_binary;
               credit_nx = '0;
`ifdef VEND_TIMEOUT_EN
               cnt_nx = '0;
               to_nx  = 1'b0;
`endif
               if (price_binary == 4'd0) begin
                  state_nx = S_DISPENSE;
                  chg_nx   = '0;
               end else begin
                  state_nx = S_COLLECT;
               end
            end
         end
         S_COLLECT: begin
            credit_nx = sum;
            if (cancel) begin
               state_nx = S_REFUND;
               chg_nx   = sum;
            end else if (sum >= CREDIT_W'(price_r)) begin
               state_nx = S_DISPENSE;
               chg_nx   = sum - CREDIT_W'(price_r);
            end
`ifdef VEND_TIMEOUT_EN
            else if (timeout_hit) begin
               state_nx = S_REFUND;
               chg_nx   = credit;
               to_nx    = 1'b1;
            end else begin
               cnt_nx = coin_valid ? '0 : cnt + 1'b1;
            end
`endif
         end
         default: begin
            state_nx  = S_IDLE;
            credit_nx = '0;
`ifdef VEND_TIMEOUT_EN
            to_nx = 1'b0;
`endif
         end
      endcase

      pay_out         = (state == S_DISPENSE) || (state == S_REFUND);
      busy_nx         = (state_nx != S_IDLE);
      dispense_nx     = (state == S_DISPENSE);
      change_valid_nx = pay_out && (chg_r != '0);
      change_nx       = pay_out ? chg_r : '0;
      coin_reject_nx  = coin_valid && (state != S_COLLECT);
`ifdef VEND_TIMEOUT_EN
      timeout_nx = (state == S_REFUND) && to_r;
`else
      timeout_nx = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         price_r      <= '0;
         credit       <= '0;
         chg_r        <= '0;
         busy         <= 1'b0;
         dispense     <= 1'b0;
         change_valid <= 1'b0;
         change       <= '0;
         coin_reject  <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state        <= state_nx;
         price_r      <= price_nx;
         credit       <= credit_nx;
         chg_r        <= chg_nx;
         busy         <= busy_nx;
         dispense     <= dispense_nx;
         change_valid <= change_valid_nx;
         change       <= change_nx;
         coin_reject  <= coin_reject_nx;
         timeout      <= timeout_nx;
      end
   end

`ifdef VEND_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         to_r <= 1'b0;
      end else begin
         cnt  <= cnt_nx;
         to_r <= to_nx;
      end
   end
`endif

endmodule
